// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared types and helpers for the piso_serializer family.
//               - piso_state_t : FSM state encoding (IDLE, SHIFT, PARITY)
//               - PISO_MAX_WIDTH : largest supported word width
//               - piso_cnt_w() : bit-counter width for a given word width
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  localparam int PISO_MAX_WIDTH = 32;

  // Counter must hold WIDTH-1, which always fits in $clog2(WIDTH) bits
  // for WIDTH >= 2.
  function automatic int piso_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : piso_bit_counter
// Description : Loadable down-counter tracking the remaining bits of a frame.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               load, value  - load 'value' (takes priority over en)
//               en           - decrement by one
//               count        - current counter value
//               zero         - count == 0 (last data bit)
// Revision    : 1.0 - initial release
// ============================================================================
module piso_bit_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (en) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in serial-out transmitter with valid/ready load
//               handshake. Streams back-to-back words with no idle gap.
// Parameters  : WIDTH     - word width (2..32)
//               MSB_FIRST - 1: bit WIDTH-1 first, 0: bit 0 first
// Config      : PISO_PARITY_EN - when defined, appends one even-parity bit
//               (XOR of the word) to every frame.
// Ports       : clk, rst    - clock, synchronous active-high reset
//               d           - parallel word, sampled on handshake
//               load_valid  - d is valid
//               load_ready  - word can be accepted this cycle
//               sout        - serial data (0 when idle)
//               sout_valid  - sout carries a frame bit
//               frame_start - pulse on first bit of a frame
//               done        - pulse on final cycle of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int               CNT_W      = piso_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

  piso_state_t      state_q;
  piso_state_t      state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  logic [WIDTH-1:0] shreg_shifted;
  logic             head_bit;
  logic             final_cycle;
  logic             accept;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;

  // --------------------------------------------------------------------------
  // Bit ordering: head bit and shift direction
  // --------------------------------------------------------------------------
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign head_bit      = shreg_q[WIDTH-1];
      assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign head_bit      = shreg_q[0];
      assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Bit counter: loaded with WIDTH-1 on accept, counts down while shifting.
  // Held at zero once the last bit is reached so it never wraps.
  // --------------------------------------------------------------------------
  piso_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .en    (cnt_en),
    .value (C_CNT_LAST),
    .count (cnt_value),
    .zero  (cnt_zero)
  );

  // --------------------------------------------------------------------------
  // Handshake: ready in IDLE or on the final cycle of a frame, so the next
  // word follows with zero gap. Held low while rst is asserted.
  // --------------------------------------------------------------------------
`ifdef PISO_PARITY_EN
  logic parity_q;
  logic parity_d;
  assign final_cycle = (state_q == PARITY);
`else
  assign final_cycle = (state_q == SHIFT) && cnt_zero;
`endif

  assign load_ready = !rst && ((state_q == IDLE) || final_cycle);
  assign accept     = load_valid && load_ready;
  assign cnt_load   = accept;
  assign cnt_en     = (state_q == SHIFT) && !cnt_zero;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = shreg_shifted;
        if (cnt_zero) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        state_d = accept ? SHIFT : IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new word overrides the shift on the same edge as the final bit.
    if (accept) begin
      shreg_d = d;
`ifdef PISO_PARITY_EN
      parity_d = ^d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Output decode (registered state only)
  // --------------------------------------------------------------------------
`ifdef PISO_PARITY_EN
  assign sout       = ((state_q == SHIFT) && head_bit) ||
                      ((state_q == PARITY) && parity_q);
  assign sout_valid = (state_q == SHIFT) || (state_q == PARITY);
`else
  assign sout       = (state_q == SHIFT) && head_bit;
  assign sout_valid = (state_q == SHIFT);
`endif
  assign frame_start = (state_q == SHIFT) && (cnt_value == C_CNT_LAST);
  assign done        = final_cycle;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Directed self-checking bench for piso_serializer (WIDTH=4).
//               Instance u_dut_msb is MSB-first, u_dut_lsb is LSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic             load_valid;
  logic             load_ready, sout, sout_valid, frame_start, done;
  logic [WIDTH-1:0] d2;
  logic             lv2;
  logic             load_ready2, sout2, sout_valid2, frame_start2, done2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk         (clk),
    .rst         (rst),
    .d           (d),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .frame_start (frame_start),
    .done        (done)
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk         (clk),
    .rst         (rst),
    .d           (d2),
    .load_valid  (lv2),
    .load_ready  (load_ready2),
    .sout        (sout2),
    .sout_valid  (sout_valid2),
    .frame_start (frame_start2),
    .done        (done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Send one word on the selected instance and check every frame cycle.
  task automatic run_frame(input logic [WIDTH-1:0] w, input bit use_lsb);
    logic exp_bit;
    if (use_lsb) begin d2 = w; lv2 = 1'b1; end
    else         begin d  = w; load_valid = 1'b1; end
    tick();
    lv2 = 1'b0;
    load_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (i < WIDTH) exp_bit = use_lsb ? w[i] : w[WIDTH-1-i];
      else           exp_bit = ^w;
      check($sformatf("sout[%0d]", i), use_lsb ? sout2 : sout, exp_bit);
      check($sformatf("sout_valid[%0d]", i), use_lsb ? sout_valid2 : sout_valid, 1'b1);
      check($sformatf("frame_start[%0d]", i), use_lsb ? frame_start2 : frame_start, i == 0);
      check($sformatf("done[%0d]", i), use_lsb ? done2 : done, i == FRAME - 1);
      check($sformatf("load_ready[%0d]", i), use_lsb ? load_ready2 : load_ready, i == FRAME - 1);
      tick();
    end
    check("idle_sout_valid", use_lsb ? sout_valid2 : sout_valid, 1'b0);
    check("idle_sout", use_lsb ? sout2 : sout, 1'b0);
    check("idle_load_ready", use_lsb ? load_ready2 : load_ready, 1'b1);
  endtask

  logic [WIDTH-1:0] words [4];

  initial begin
    words[0] = 4'b0001;
    words[1] = 4'b1001;
    words[2] = 4'b0110;
    words[3] = 4'b1101;

    // ---------------- Reset held 3 cycles with a word offered ----------------
    rst = 1'b1;
    d = 4'b1111; load_valid = 1'b1;
    d2 = 4'b1111; lv2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_sout", sout, 1'b0);
      check("rst_sout_valid", sout_valid, 1'b0);
      check("rst_frame_start", frame_start, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_load_ready", load_ready, 1'b0);
      check("rst_load_ready_lsb", load_ready2, 1'b0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_load_ready", load_ready, 1'b1);
    load_valid = 1'b0;
    lv2 = 1'b0;
    tick();
    check("post_rst_no_accept", sout_valid, 1'b0);
    check("post_rst_no_accept_lsb", sout_valid2, 1'b0);

    // ---------------- Single frame, MSB first -------------------------------
    run_frame(4'b1001, 1'b0);

    // ---------------- Single frame, LSB first -------------------------------
    run_frame(4'b0110, 1'b1);

`ifdef PISO_PARITY_EN
    // ---------------- Parity frame: 1,1,0,1 then parity 1 -------------------
    run_frame(4'b1101, 1'b0);
`endif

    // ---------------- Streaming four words with load_valid held -------------
    d = words[0];
    load_valid = 1'b1;
    tick();
    d = words[1];
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        check($sformatf("stream_sout[%0d.%0d]", f, i), sout,
              (i < WIDTH) ? words[f][WIDTH-1-i] : ^words[f]);
        check($sformatf("stream_valid[%0d.%0d]", f, i), sout_valid, 1'b1);
        check($sformatf("stream_ready[%0d.%0d]", f, i), load_ready, i == FRAME - 1);
        check($sformatf("stream_start[%0d.%0d]", f, i), frame_start, i == 0);
        if (f == 3 && i == FRAME - 1) load_valid = 1'b0;
        tick();
        if (i == FRAME - 1 && f < 2) d = words[f+2];
      end
    end
    check("stream_end_valid", sout_valid, 1'b0);

    // ---------------- Mid-frame reset ---------------------------------------
    d = 4'b1010;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("mid_bit0", sout, 1'b1);
    tick();
    check("mid_bit1", sout, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", load_ready, 1'b0);
    tick();
    check("mid_rst_sout", sout, 1'b0);
    check("mid_rst_valid", sout_valid, 1'b0);
    check("mid_rst_done", done, 1'b0);
    rst = 1'b0;
    run_frame(4'b1010, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out transmitter for the shift-register family. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock on a serial line with a frame qualifier. It is the transmit end for the serial-in parallel-out receivers: its sout/sout_valid pair drives a SIPO's serial input directly. Back-to-back words stream with no idle gap.

## Interface
- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset. Sampled only on the rising edge of clk.
- d  input  WIDTH  parallel word to send; sampled on handshake.
- load_valid  input  1  d is valid.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data; 0 when not transmitting.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  one-cycle pulse on the first bit of each frame.
- done  output  1  one-cycle pulse on the last bit of each frame.

## Operation
- State machine (piso_state_t) with states IDLE, SHIFT and, only when PARITY is compiled in, PARITY.
- Accept: a word is accepted when load_valid && load_ready at a rising edge. On accept:
  - d is captured into the shift register.
  - bit counter is set to WIDTH-1.
  - FSM enters SHIFT.
- SHIFT:
  - sout is the head bit of the shift register: MSB when MSB_FIRST=1, LSB when MSB_FIRST=0.
  - Each edge shifts by one and decrements the counter.
  - Counter value 0 marks the last bit.
- At the last bit:
  - Without PARITY: if a new word is accepted, stay in SHIFT with the new word loaded; otherwise go to IDLE.
  - With PARITY: go to PARITY.
- PARITY: sout = parity bit for one cycle. Then reload from a pending accept, or return to IDLE.
- load_ready = (state == IDLE) or (final frame cycle), forced 0 while rst is high. The final frame cycle is the last data bit without PARITY, or the PARITY cycle with it.
- d and load_valid are ignored whenever load_ready = 0. No input buffering is provided.

## Timing
- Reset values: state IDLE, shift register 0, counter 0, sout 0, sout_valid 0, frame_start 0, done 0, load_ready 0.
- load_ready rises to 1 in the first cycle after rst deasserts.
- Latency: a word accepted at edge N drives its first bit during cycle N+1. Its last data bit appears during cycle N+WIDTH.
- Frame length is WIDTH cycles, or WIDTH+1 with PARITY.
- Streaming: if load_valid is held high, sout_valid stays continuously 1 across frames with zero gap cycles.
- frame_start is high in the first bit cycle of a frame. done is high in the final frame cycle. For WIDTH ≥ 2 these never coincide.
- Simultaneous accept and final bit: the outgoing final bit is driven unchanged and the new word's first bit follows on the next cycle.
- Reset mid-frame: at the reset edge the frame is aborted and all outputs return to reset values. No done pulse is issued.
- All outputs are registered or decoded from registered state only. There is no combinational path from d or load_valid to sout.

## Configuration
- Macro PISO_PARITY_EN.
  - Defined: each frame is extended by one trailing even-parity bit, equal to the XOR of the captured word. The PARITY state exists, sout_valid is high during that cycle, and done moves to the parity cycle.
  - Undefined: the PARITY state is not compiled in and frames are exactly WIDTH bits.

## Structure
- Shared package piso_pkg holds:
  - typedef piso_state_t (IDLE, SHIFT, PARITY).
  - Constant PISO_MAX_WIDTH = 32.
  - Function piso_cnt_w(WIDTH), returning the counter width as $clog2(WIDTH).
- One sub-module, piso_bit_counter:
  - Loadable down-counter with load, en and value inputs.
  - Exposes a zero flag used for the last-bit decode.
- Top level holds the FSM, shift register and output decode.

## Test plan
- Reset: hold rst for 3 cycles with load_valid=1 and d=4'b1111 → all outputs 0 and no accept. load_ready=1 on the first cycle after release.
- Single frame, MSB_FIRST=1, WIDTH=4:
  - Stimulus: d=4'b1001 accepted at edge N.
  - Response: sout = 1,0,0,1 on cycles N+1..N+4.
  - frame_start at N+1, done at N+4, then IDLE with sout_valid=0.
- LSB first: MSB_FIRST=0 with d=4'b0110 → sout = 0,1,1,0.
- Streaming:
  - Stimulus: load_valid held high with d = 4'b0001, 4'b1001, 4'b0110, 4'b1101 presented on successive accepts.
  - Response: 16 contiguous valid bits 0001_1001_0110_1101.
  - load_ready is high only on the accept cycles.
- Parity (PISO_PARITY_EN defined): d=4'b1101 → sout = 1,1,0,1 followed by parity 1. done is on the 5th bit.
- Mid-frame reset: assert rst after 2 bits of 4'b1010 → sout and sout_valid are 0 from the next cycle. A new word sent after release is transmitted intact.
